// File: rtl/o9_mem_pkg.sv
// Package o9_mem_pkg
// Shared defaults and enumerations for the fetch/load-store RAM arbiter.
//   DEF_ADDR_W        default RAM word-address width
//   DEF_DATA_W        default RAM word width
//   DEF_DEPTH         default number of implemented words
//   DEF_STARVE_LIMIT  default consecutive fetch losses before fetch is forced
//   state_t           arbiter FSM states
//   gnt_t             identity of the granted port
package o9_mem_pkg;

  localparam int DEF_ADDR_W       = 16;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_DEPTH        = 1024;
  localparam int DEF_STARVE_LIMIT = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef enum logic {
    GNT_F = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

endpackage

// File: rtl/o9_arb_prio.sv
// Module o9_arb_prio
// Picks the winner between the fetch and load/store ports. Load/store has
// priority unless fetch has lost STARVE_LIMIT consecutive contested grants,
// in which case an eligible fetch is forced to win.
// Ports:
//   clock       in  rising-edge clock
//   reset       in  asynchronous active-high reset (clears starve count)
//   f_elig      in  fetch request is eligible this cycle
//   d_elig      in  load/store request is eligible this cycle
//   grant_fire  in  a grant is being taken at the next edge
//   gnt_f       out fetch wins (combinational)
//   gnt_d       out load/store wins (combinational)
module o9_arb_prio
  import o9_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clock,
  input  logic reset,
  input  logic f_elig,
  input  logic d_elig,
  input  logic grant_fire,
  output logic gnt_f,
  output logic gnt_d
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_reg;
  logic [CW-1:0] starve_next;
  logic          force_f;

  // Fetch is forced only when it is actually asking; otherwise d keeps priority.
  assign force_f = (starve_reg == LIMIT) && f_elig;
  assign gnt_d   = d_elig && !force_f;
  assign gnt_f   = f_elig && !gnt_d;

  always_comb begin
    starve_next = starve_reg;
    if (grant_fire) begin
      if (gnt_f) begin
        starve_next = '0;
      end else if (f_elig && gnt_d && (starve_reg != LIMIT)) begin
        starve_next = starve_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_reg <= '0;
    end else begin
      starve_reg <= starve_next;
    end
  end

endmodule

// File: rtl/mem_arbiter_o9.sv
// Module mem_arbiter_o9
// Shares a single-port RAM between the CPU instruction-fetch port (f_*) and
// the load/store port (d_*). A request is granted in IDLE, latched, driven to
// the RAM for exactly one ACCESS cycle, and answered with a one-cycle ack plus
// registered read data.
// Ports:
//   clock, reset                 clock / asynchronous active-high reset
//   f_req, f_addr                fetch request and word address
//   f_ack, f_rdata, f_err        fetch completion pulse, data, out-of-range flag
//   d_req, d_we, d_addr, d_wdata load/store request, write enable, address, data
//   d_ack, d_rdata, d_err        load/store completion pulse, data, out-of-range flag
//   mem_address, mem_data        RAM address / write data
//   mem_wren                     RAM write enable
//   mem_q                        RAM read data (combinational from mem_address)
//   busy                         high during the ACCESS cycle
module mem_arbiter_o9
  import o9_mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_t            state_reg;
  state_t            state_next;
  gnt_t              port_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              we_reg;
  logic [DATA_W-1:0] wdata_reg;

  logic f_elig;
  logic d_elig;
  logic gnt_f;
  logic gnt_d;
  logic grant_fire;
  logic in_range;

  // A port is not re-granted in the cycle its ack is showing, which is what
  // lets the other port slip in between back-to-back requests.
  assign f_elig     = f_req && !f_ack;
  assign d_elig     = d_req && !d_ack;
  assign grant_fire = (state_reg == IDLE) && (f_elig || d_elig);
  assign in_range   = {1'b0, addr_reg} < DEPTH_L;

  o9_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clock      (clock),
    .reset      (reset),
    .f_elig     (f_elig),
    .d_elig     (d_elig),
    .grant_fire (grant_fire),
    .gnt_f      (gnt_f),
    .gnt_d      (gnt_d)
  );

  // FSM: IDLE -> ACCESS on a grant, ACCESS always lasts one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_fire) state_next = ACCESS;
      ACCESS:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Request latch: the winner's command is frozen at the grant edge, so later
  // changes on the request inputs cannot disturb the access in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      port_reg  <= GNT_F;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
    end else if (grant_fire) begin
      port_reg  <= gnt_f ? GNT_F : GNT_D;
      addr_reg  <= gnt_f ? f_addr : d_addr;
      we_reg    <= gnt_d && d_we;
      wdata_reg <= gnt_f ? '0 : d_wdata;
    end
  end

  // RAM drive. The address register only changes on a grant, so in IDLE the
  // RAM keeps seeing the last address. mem_wren is decoded from the state
  // register so an asynchronous reset kills a pending write immediately.
  assign busy        = (state_reg == ACCESS);
  assign mem_address = addr_reg;
  assign mem_data    = wdata_reg;
  assign mem_wren    = busy && we_reg && in_range;

  // Response registers, loaded at the edge that ends ACCESS.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      f_ack   <= 1'b0;
      f_err   <= 1'b0;
      f_rdata <= '0;
      d_ack   <= 1'b0;
      d_err   <= 1'b0;
      d_rdata <= '0;
    end else begin
      f_ack <= 1'b0;
      f_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      if (state_reg == ACCESS) begin
        if (port_reg == GNT_F) begin
          f_ack   <= 1'b1;
          f_err   <= !in_range;
          f_rdata <= in_range ? mem_q : '0;
        end else begin
          d_ack   <= 1'b1;
          d_err   <= !in_range;
          d_rdata <= (in_range && !we_reg) ? mem_q : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_o9.sv
// Directed testbench for mem_arbiter_o9 with a behavioural RAM attached.
module tb_mem_arbiter_o9;

  logic        clock;
  logic        reset;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_ack;
  logic [31:0] f_rdata;
  logic        f_err;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [15:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [0:1023];

  mem_arbiter_o9 dut (
    .clock       (clock),
    .reset       (reset),
    .f_req       (f_req),
    .f_addr      (f_addr),
    .f_ack       (f_ack),
    .f_rdata     (f_rdata),
    .f_err       (f_err),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ack       (d_ack),
    .d_rdata     (d_rdata),
    .d_err       (d_err),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM: combinational read, clocked write; out-of-range addresses read 0.
  assign mem_q = (mem_address < 16'd1024) ? ram[mem_address[9:0]] : 32'h0;
  always @(posedge clock) begin
    if (mem_wren && mem_address < 16'd1024) ram[mem_address[9:0]] <= mem_data;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-18s observed %h expected %h", tag, obs, exp);
  endtask

  int n_fack;
  int n_dack;
  int n_both;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[0] = 32'hA5A5A5A5;
    ram[5] = 32'hDEADBEEF;
    ram[9] = 32'h11111111;

    reset = 1'b1; f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    step(); step();

    // Reset state
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wren", 32'(mem_wren), 32'h0);
    chk("rst_acks", {30'h0, f_ack, d_ack}, 32'h0);
    chk("rst_errs", {30'h0, f_err, d_err}, 32'h0);
    chk("rst_f_rdata", f_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_mem_addr", 32'(mem_address), 32'h0);
    chk("rst_mem_data", mem_data, 32'h0);
    reset = 1'b0;
    step();

    // Fetch from address 5
    f_req = 1'b1; f_addr = 16'd5;
    step();
    chk("fetch_busy", 32'(busy), 32'h1);
    chk("fetch_noack", 32'(f_ack), 32'h0);
    chk("fetch_addr", 32'(mem_address), 32'd5);
    chk("fetch_wren", 32'(mem_wren), 32'h0);
    step();
    chk("fetch_ack", 32'(f_ack), 32'h1);
    chk("fetch_rdata", f_rdata, 32'hDEADBEEF);
    chk("fetch_err", 32'(f_err), 32'h0);
    chk("fetch_no_dack", 32'(d_ack), 32'h0);
    chk("fetch_idle", 32'(busy), 32'h0);
    f_req = 1'b0;
    step();
    chk("fetch_ack_1cyc", 32'(f_ack), 32'h0);
    chk("idle_addr_hold", 32'(mem_address), 32'd5);

    // Store 0x12345678 to address 7, then load it back
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'd7; d_wdata = 32'h12345678;
    step();
    chk("store_wren", 32'(mem_wren), 32'h1);
    chk("store_addr", 32'(mem_address), 32'd7);
    chk("store_data", mem_data, 32'h12345678);
    step();
    chk("store_ack", 32'(d_ack), 32'h1);
    chk("store_rdata", d_rdata, 32'h0);
    chk("store_err", 32'(d_err), 32'h0);
    chk("store_wren_off", 32'(mem_wren), 32'h0);
    d_req = 1'b0;
    step();
    chk("store_ram7", ram[7], 32'h12345678);
    d_req = 1'b1; d_we = 1'b0; d_wdata = 32'h0;
    step();
    chk("load_wren", 32'(mem_wren), 32'h0);
    step();
    chk("load_ack", 32'(d_ack), 32'h1);
    chk("load_rdata", d_rdata, 32'h12345678);
    d_req = 1'b0;
    step();

    // Simultaneous requests: load/store first, fetch on the following grant
    f_req = 1'b1; f_addr = 16'd5;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'd7;
    step();
    chk("both_gnt_d_addr", 32'(mem_address), 32'd7);
    step();
    chk("both_d_ack", {30'h0, f_ack, d_ack}, 32'h1);
    chk("both_d_rdata", d_rdata, 32'h12345678);
    d_req = 1'b0;
    step();
    chk("both_gnt_f_addr", 32'(mem_address), 32'd5);
    chk("both_gnt_f_busy", 32'(busy), 32'h1);
    step();
    chk("both_f_ack", {30'h0, f_ack, d_ack}, 32'h2);
    chk("both_f_rdata", f_rdata, 32'hDEADBEEF);
    f_req = 1'b0;
    step();

    // Both held continuously: service alternates d,f,d,f,... and acks never overlap
    n_fack = 0; n_dack = 0; n_both = 0;
    f_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (f_ack) n_fack++;
      if (d_ack) n_dack++;
      if (f_ack && d_ack) n_both++;
    end
    chk("alt_f_acks", 32'(n_fack), 32'd3);
    chk("alt_d_acks", 32'(n_dack), 32'd3);
    chk("alt_both_acks", 32'(n_both), 32'd0);
    f_req = 1'b0; d_req = 1'b0;
    step(); step();

    // Starvation: fetch loses three contested grants, then is forced to win
    for (int r = 0; r < 3; r++) begin
      f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 16'd7;
      step();
      chk("starve_gnt_d", 32'(mem_address), 32'd7);
      f_req = 1'b0;
      step();
      chk("starve_d_ack", {30'h0, f_ack, d_ack}, 32'h1);
      d_req = 1'b0;
      step();
    end
    f_req = 1'b1; d_req = 1'b1;
    step();
    chk("forced_gnt_f", 32'(mem_address), 32'd5);
    step();
    chk("forced_f_ack", {30'h0, f_ack, d_ack}, 32'h2);
    f_req = 1'b0;
    step();
    chk("after_force_d", 32'(mem_address), 32'd7);
    step();
    chk("after_force_dack", 32'(d_ack), 32'h1);
    d_req = 1'b0;
    step();
    // Count was cleared by the forced grant, so a contested grant goes to d again
    f_req = 1'b1; d_req = 1'b1;
    step();
    chk("cleared_gnt_d", 32'(mem_address), 32'd7);
    f_req = 1'b0;
    step();
    d_req = 1'b0;
    step();

    // Out-of-range store: error ack, no write
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'd1024; d_wdata = 32'hCAFEF00D;
    step();
    chk("oor_busy", 32'(busy), 32'h1);
    chk("oor_wren", 32'(mem_wren), 32'h0);
    step();
    chk("oor_ack", 32'(d_ack), 32'h1);
    chk("oor_err", 32'(d_err), 32'h1);
    chk("oor_rdata", d_rdata, 32'h0);
    d_req = 1'b0;
    step();
    chk("oor_ram0", ram[0], 32'hA5A5A5A5);
    chk("oor_err_clear", 32'(d_err), 32'h0);

    // Reset asserted during the ACCESS cycle of a store
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'd9; d_wdata = 32'h55AA55AA;
    step();
    chk("rstw_wren_on", 32'(mem_wren), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("rstw_wren_off", 32'(mem_wren), 32'h0);
    chk("rstw_busy", 32'(busy), 32'h0);
    chk("rstw_mem_addr", 32'(mem_address), 32'h0);
    chk("rstw_mem_data", mem_data, 32'h0);
    chk("rstw_d_rdata", d_rdata, 32'h0);
    step();
    d_req = 1'b0;
    chk("rstw_ack", {30'h0, f_ack, d_ack}, 32'h0);
    chk("rstw_ram9", ram[9], 32'h11111111);
    reset = 1'b0;
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'd9; d_wdata = 32'h0;
    step();
    chk("rstw_next_busy", 32'(busy), 32'h1);
    step();
    chk("rstw_next_ack", 32'(d_ack), 32'h1);
    chk("rstw_next_rdata", d_rdata, 32'h11111111);
    d_req = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
